// File: rtl/pc_update.sv
// Program-counter stage: holds PC, latches PC+4 and branch target, commits one next-PC source on PCWrite.
// Latency: 1 cycle from PCWrite to CurPC/Redirect; strobe-driven, no backpressure (strobes accepted every cycle).
// Optional PC_HISTORY_EN adds a redirect-history buffer read through HistIdx/HistData.
module pc_update #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          HIST_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LatchPC4,
    input  logic        LatchTgt,
    input  logic        PCWrite,
    input  logic [1:0]  PCSrc,
    input  logic        BranchTaken,
    input  logic [31:0] ShiftedOff,
    input  logic [25:0] JumpIdx,
    input  logic [31:0] RegAddr,
    input  logic        FaultClr,
`ifdef PC_HISTORY_EN
    input  logic [$clog2(HIST_DEPTH)-1:0] HistIdx,
    output logic [31:0] HistData,
`endif
    output logic [31:0] CurPC,
    output logic [31:0] PCPlus4,
    output logic [31:0] BranchTarget,
    output logic        Redirect,
    output logic        PCFault
);

    if (HIST_DEPTH < 2 || HIST_DEPTH > 16 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_update: HIST_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic {NO_TGT, TGT_HELD} tgt_state_t;

    tgt_state_t  state, state_nxt;
    logic [31:0] next_pc;
    logic [31:0] jump_tgt;
    logic        fault_new;
    logic        commit_fault;
    logic        commit_redirect;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= NO_TGT;
        else      state <= state_nxt;
    end

    // A new fetch invalidates any held target; a reload wins over the commit that consumes the old one.
    always_comb begin
        state_nxt = state;
        if (LatchPC4)      state_nxt = NO_TGT;
        else if (LatchTgt) state_nxt = TGT_HELD;
        else if (PCWrite)  state_nxt = NO_TGT;
    end

    assign jump_tgt = {PCPlus4[31:28], JumpIdx, 2'b00};

    always_comb begin
        next_pc   = PCPlus4;
        fault_new = 1'b0;
        case (PCSrc)
            2'b00: next_pc = PCPlus4;
            2'b01: begin
                if (BranchTaken) begin
                    if (state == TGT_HELD) next_pc = BranchTarget;
                    else                   fault_new = 1'b1;
                end
            end
            2'b10: next_pc = jump_tgt;
            default: begin
                if (RegAddr[1:0] == 2'b00) begin
                    next_pc = RegAddr;
                end else begin
                    next_pc   = CurPC;
                    fault_new = 1'b1;
                end
            end
        endcase
    end

    assign commit_fault    = PCWrite && fault_new;
    assign commit_redirect = PCWrite && !fault_new && (next_pc != PCPlus4);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CurPC        <= RESET_PC;
            PCPlus4      <= RESET_PC + 32'd4;
            BranchTarget <= 32'h0;
            Redirect     <= 1'b0;
            PCFault      <= 1'b0;
        end else begin
            if (PCWrite)  CurPC        <= next_pc;
            if (LatchPC4) PCPlus4      <= CurPC + 32'd4;
            if (LatchTgt) BranchTarget <= PCPlus4 + ShiftedOff;
            Redirect <= commit_redirect;
            // A fault raised on the same edge as a clear must survive.
            if (commit_fault)  PCFault <= 1'b1;
            else if (FaultClr) PCFault <= 1'b0;
        end
    end

`ifdef PC_HISTORY_EN
    localparam int HW = $clog2(HIST_DEPTH);

    logic [31:0]   hist [HIST_DEPTH];
    logic [HW-1:0] wr_ptr;
    logic [HW-1:0] rd_ptr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= 32'h0;
        end else if (commit_redirect) begin
            hist[wr_ptr] <= CurPC;
            wr_ptr       <= wr_ptr + HW'(1);
        end
    end

    // Entry 0 is the slot just behind the write pointer.
    assign rd_ptr   = wr_ptr - HistIdx - HW'(1);
    assign HistData = hist[rd_ptr];
`endif

endmodule

// File: tb/tb_pc_update.sv
// Directed self-checking bench for pc_update with RESET_PC = 0x0040_0000.
module tb_pc_update;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LatchPC4 = 1'b0;
    logic        LatchTgt = 1'b0;
    logic        PCWrite = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic        BranchTaken = 1'b0;
    logic [31:0] ShiftedOff = 32'h0;
    logic [25:0] JumpIdx = 26'h0;
    logic [31:0] RegAddr = 32'h0;
    logic        FaultClr = 1'b0;
    logic [31:0] CurPC, PCPlus4, BranchTarget;
    logic        Redirect, PCFault;
`ifdef PC_HISTORY_EN
    logic [1:0]  HistIdx = 2'd0;
    logic [31:0] HistData;
`endif

    int total = 0;
    int bad   = 0;

    pc_update #(.RESET_PC(32'h0040_0000), .HIST_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .LatchPC4(LatchPC4), .LatchTgt(LatchTgt), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .BranchTaken(BranchTaken), .ShiftedOff(ShiftedOff), .JumpIdx(JumpIdx),
        .RegAddr(RegAddr), .FaultClr(FaultClr),
`ifdef PC_HISTORY_EN
        .HistIdx(HistIdx), .HistData(HistData),
`endif
        .CurPC(CurPC), .PCPlus4(PCPlus4), .BranchTarget(BranchTarget),
        .Redirect(Redirect), .PCFault(PCFault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge with the current strobes, then all strobes dropped; sampled 1 after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
        LatchPC4 = 1'b0; LatchTgt = 1'b0; PCWrite = 1'b0; FaultClr = 1'b0; BranchTaken = 1'b0;
    endtask

    task automatic jr(input logic [31:0] addr);
        PCWrite = 1'b1; PCSrc = 2'b11; RegAddr = addr;
        step();
    endtask

    initial begin
        #3 RST = 1'b0;
        #1;
        chk("rst_pc",   CurPC,        32'h0040_0000);
        chk("rst_pc4",  PCPlus4,      32'h0040_0004);
        chk("rst_tgt",  BranchTarget, 32'h0);
        chk("rst_flags", {30'd0, Redirect, PCFault}, 32'h0);
        @(negedge CLK) RST = 1'b1;

        // Backward branch: target = 0x0040_0004 - 8.
        LatchPC4 = 1'b1; step();
        chk("pc4_latch", PCPlus4, 32'h0040_0004);
        LatchTgt = 1'b1; ShiftedOff = 32'hFFFF_FFF8; step();
        chk("tgt_latch", BranchTarget, 32'h003F_FFFC);
        PCWrite = 1'b1; PCSrc = 2'b01; BranchTaken = 1'b1; step();
        chk("br_pc",    CurPC,    32'h003F_FFFC);
        chk("br_redir", {31'd0, Redirect}, 32'd1);
        chk("br_nofault", {31'd0, PCFault}, 32'd0);
        step();
        chk("redir_pulse", {31'd0, Redirect}, 32'd0);

        // Taken branch with no target since the last fetch.
        LatchPC4 = 1'b1; step();
        chk("pc4_b", PCPlus4, 32'h0040_0000);
        PCWrite = 1'b1; PCSrc = 2'b01; BranchTaken = 1'b1; step();
        chk("notgt_pc",    CurPC, 32'h0040_0000);
        chk("notgt_fault", {31'd0, PCFault}, 32'd1);
        chk("notgt_redir", {31'd0, Redirect}, 32'd0);
        step();
        chk("fault_sticky", {31'd0, PCFault}, 32'd1);
        FaultClr = 1'b1; step();
        chk("fault_clr", {31'd0, PCFault}, 32'd0);

        // Jump from 0x1000_0008.
        jr(32'h1000_0008);
        chk("jr_pc",    CurPC, 32'h1000_0008);
        chk("jr_redir", {31'd0, Redirect}, 32'd1);
        LatchPC4 = 1'b1; step();
        PCWrite = 1'b1; PCSrc = 2'b10; JumpIdx = 26'h000_0040; step();
        chk("j_pc",    CurPC, 32'h1000_0100);
        chk("j_redir", {31'd0, Redirect}, 32'd1);

        // Misaligned jr holds PC; clear racing a new fault keeps the flag.
        jr(32'h1000_0202);
        chk("jrbad_pc",    CurPC, 32'h1000_0100);
        chk("jrbad_fault", {31'd0, PCFault}, 32'd1);
        chk("jrbad_redir", {31'd0, Redirect}, 32'd0);
        FaultClr = 1'b1; PCWrite = 1'b1; PCSrc = 2'b11; RegAddr = 32'h0000_0001; step();
        chk("clr_vs_fault", {31'd0, PCFault}, 32'd1);
        FaultClr = 1'b1; step();
        chk("clr2", {31'd0, PCFault}, 32'd0);

        // Wrap: 0xFFFF_FFFC + 4 = 0.
        jr(32'hFFFF_FFFC);
        LatchPC4 = 1'b1; step();
        chk("wrap_pc4", PCPlus4, 32'h0);
        PCWrite = 1'b1; PCSrc = 2'b00; step();
        chk("wrap_pc",    CurPC, 32'h0);
        chk("wrap_redir", {31'd0, Redirect}, 32'd0);

        // Branch not taken with a held target.
        LatchPC4 = 1'b1; step();
        LatchTgt = 1'b1; ShiftedOff = 32'h10; step();
        chk("nt_tgt", BranchTarget, 32'h14);
        PCWrite = 1'b1; PCSrc = 2'b01; BranchTaken = 1'b0; step();
        chk("nt_pc",    CurPC, 32'h4);
        chk("nt_flags", {30'd0, Redirect, PCFault}, 32'h0);

        // LatchPC4 + LatchTgt together: both use pre-edge values, target not held.
        LatchPC4 = 1'b1; LatchTgt = 1'b1; step();
        chk("dual_pc4", PCPlus4, 32'h8);
        chk("dual_tgt", BranchTarget, 32'h14);
        PCWrite = 1'b1; PCSrc = 2'b01; BranchTaken = 1'b1; step();
        chk("dual_pc",    CurPC, 32'h8);
        chk("dual_fault", {31'd0, PCFault}, 32'd1);

        // Reset asserted while a commit is pending.
        @(negedge CLK);
        PCWrite = 1'b1; PCSrc = 2'b11; RegAddr = 32'h0000_0100;
        #1 RST = 1'b0;
        #1;
        chk("mid_rst_pc",    CurPC,   32'h0040_0000);
        chk("mid_rst_pc4",   PCPlus4, 32'h0040_0004);
        chk("mid_rst_flags", {30'd0, Redirect, PCFault}, 32'h0);
        PCWrite = 1'b0;
        @(negedge CLK) RST = 1'b1;

        // Five redirects; history keeps the last four source PCs.
        for (int i = 1; i <= 5; i++) jr(32'(i) << 12);
        chk("hist_pc", CurPC, 32'h0000_5000);
`ifdef PC_HISTORY_EN
        HistIdx = 2'd0; #1 chk("hist0", HistData, 32'h0000_4000);
        HistIdx = 2'd1; #1 chk("hist1", HistData, 32'h0000_3000);
        HistIdx = 2'd2; #1 chk("hist2", HistData, 32'h0000_2000);
        HistIdx = 2'd3; #1 chk("hist3", HistData, 32'h0000_1000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
